// File: rtl/rf_exec_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the register-file sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rf_exec_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Every op except LDI takes its operands from the register file.
    function automatic logic needs_read(input logic [2:0] op);
        return op != OP_LDI;
    endfunction

endpackage

// File: rtl/rf_exec_alu.sv
// Combinational 16-bit ALU: (op, a, b, imm) -> (result, carry).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the sequencer decides when the output is captured.
module rf_exec_alu
    import rf_exec_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    // One extra bit on add/subtract gives the carry-out and the unsigned borrow (a < b).
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin result = sum[DW-1:0];  carry = sum[DW];  end
            OP_SUB: begin result = diff[DW-1:0]; carry = diff[DW]; end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_MOV: result = a;
            OP_LDI: result = imm;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Single-issue sequencer: read two registers, run the ALU, write back rd, return result and flags.
// Latency: rsp_valid 4 cycles after the accept cycle for ALU ops, 3 for LDI; one op in flight.
// Backpressure: cmd_ready is low outside IDLE; RESP holds a stable payload until rsp_ready.
module rf_exec_ctrl
    import rf_exec_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_carry,
    output logic          rf_wr,
    output logic [AW-1:0] rf_wr_addr,
    output logic [AW-1:0] rf_rd_addr_a,
    output logic [AW-1:0] rf_rd_addr_b,
    output logic [DW-1:0] rf_d_in,
    input  logic [DW-1:0] rf_d_out_a,
    input  logic [DW-1:0] rf_d_out_b
);

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] result_q;
    logic          carry_q;
    logic          zero_q;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    assign accept = cmd_valid & cmd_ready;

    rf_exec_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; LDI skips the register read.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = needs_read(cmd_op) ? S_READ : S_EXEC;
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the command, capture operands, register the ALU result and the
    // registered strobes. The result register feeds both the write port and the response,
    // so the payload cannot change while RESP waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            rf_rd_addr_a <= '0;
            rf_rd_addr_b <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            rf_wr        <= 1'b0;
            rsp_valid    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                imm_q <= cmd_imm;
                if (needs_read(cmd_op)) begin
                    rf_rd_addr_a <= cmd_rs1;
                    rf_rd_addr_b <= cmd_rs2;
                end
            end
            if (state_q == S_READ) begin
                opa_q <= rf_d_out_a;
                opb_q <= rf_d_out_b;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_result;
                carry_q  <= alu_carry;
                zero_q   <= (alu_result == '0);
            end
            rf_wr     <= (state_d == S_WRITE);
            rsp_valid <= (state_d == S_RESP);
        end
    end

    assign rf_wr_addr = rd_q;
    assign rf_d_in    = result_q;
    assign rsp_data   = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_carry  = carry_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Self-checking bench for rf_exec_ctrl with a behavioural register file and reference model.
// Latency: checks accept-to-response timing of 4 cycles (ALU) and 3 cycles (LDI).
// Backpressure: stalls rsp_ready and offers commands while busy to confirm they are not consumed.
module tb_rf_exec_ctrl;

    localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_XOR = 3'd4, T_MOV = 3'd6, T_LDI = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [15:0] cmd_imm = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_carry;
    logic        rf_wr;
    logic [2:0]  rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b;
    logic [15:0] rf_d_in, rf_d_out_a, rf_d_out_b;

    logic [15:0] tb_rf [8];
    logic [15:0] ref_rf [8];
    int          wr_cnt = 0;
    logic [2:0]  last_wa = '0;
    logic [15:0] last_wd = '0;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rf_exec_ctrl #(.DW(16), .AW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rf_wr        (rf_wr),
        .rf_wr_addr   (rf_wr_addr),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_d_in      (rf_d_in),
        .rf_d_out_a   (rf_d_out_a),
        .rf_d_out_b   (rf_d_out_b)
    );

    // Behavioural register file: combinational reads, write on the clock edge.
    assign rf_d_out_a = tb_rf[rf_rd_addr_a];
    assign rf_d_out_b = tb_rf[rf_rd_addr_b];

    always @(posedge clk) begin
        if (rf_wr) begin
            tb_rf[rf_wr_addr] <= rf_d_in;
            wr_cnt            <= wr_cnt + 1;
            last_wa           <= rf_wr_addr;
            last_wd           <= rf_d_in;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference semantics with plain integer arithmetic: {carry, result}.
    function automatic logic [16:0] model(input logic [2:0] op, input int a, input int b, input int imm);
        int   r;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: begin r = a + b; c = (r > 65535); r = r % 65536; end
            3'd1: begin c = (a < b); r = (a - b + 65536) % 65536; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 65535 - a;
            3'd6: r = a;
            default: r = imm;
        endcase
        return {c, r[15:0]};
    endfunction

    // Issue one command starting at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic do_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm, input int stall,
                         output logic [15:0] d, output logic z, output logic c);
        logic [16:0] m;
        int          cyc;
        int          wr0;
        logic        busy_rdy;
        logic        stall_bad;
        m = model(op, ref_rf[rs1], ref_rf[rs2], imm);
        d = '0; z = 1'b0; c = 1'b0;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        rsp_ready = (stall == 0);
        check("accept_ready", cmd_ready, 1);
        wr0 = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        busy_rdy = 1'b0;
        while (!rsp_valid && cyc < 20) begin
            if (cmd_ready) busy_rdy = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, (op == T_LDI) ? 3 : 4);
        if (!rsp_valid) begin
            rsp_ready = 1'b1;
            return;
        end
        check("busy_cmd_ready", busy_rdy, 0);
        d = rsp_data; z = rsp_zero; c = rsp_carry;
        check("rsp_data", rsp_data, m[15:0]);
        check("rsp_zero", rsp_zero, m[15:0] == 16'h0);
        check("rsp_carry", rsp_carry, m[16]);
        check("wr_addr", last_wa, rd);
        check("wr_data", last_wd, m[15:0]);
        stall_bad = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // Offer a junk command during the stall; it must not be consumed.
            cmd_op = T_LDI; cmd_rd = 3'd0; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d || rsp_zero !== z || rsp_carry !== c || cmd_ready)
                stall_bad = 1'b1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        if (stall > 0) check("stall_hold", stall_bad, 0);
        ref_rf[rd] = m[15:0];
        @(negedge clk);
        check("rsp_done", rsp_valid, 0);
        check("idle_ready", cmd_ready, 1);
        check("wr_pulses", wr_cnt - wr0, 1);
    endtask

    initial begin
        logic [15:0] d;
        logic        z, c;
        int          wr0;
        for (int i = 0; i < 8; i++) begin
            tb_rf[i]  = '0;
            ref_rf[i] = '0;
        end

        // Post-reset state.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rf_wr", rf_wr, 0);
        check("rst_outputs", {rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b, rf_d_in, rsp_data, rsp_zero, rsp_carry}, 0);

        // LDI and carry/borrow.
        do_op(T_LDI, 3'd3, 3'd0, 3'd0, 16'h00FF, 0, d, z, c);
        check("ldi_r3", {c, z, d}, {1'b0, 1'b0, 16'h00FF});
        do_op(T_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 0, d, z, c);
        do_op(T_LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 0, d, z, c);
        do_op(T_ADD, 3'd4, 3'd1, 3'd2, 16'h0, 0, d, z, c);
        check("add_wrap", {c, z, d}, {1'b1, 1'b1, 16'h0000});
        do_op(T_SUB, 3'd5, 3'd2, 3'd1, 16'h0, 0, d, z, c);
        check("sub_borrow", {c, d}, {1'b1, 16'h0002});

        // Back-to-back dependent ops.
        do_op(T_LDI, 3'd1, 3'd0, 3'd0, 16'h0003, 0, d, z, c);
        do_op(T_ADD, 3'd1, 3'd1, 3'd1, 16'h0, 0, d, z, c);
        check("dep_first", d, 16'h0006);
        do_op(T_ADD, 3'd1, 3'd1, 3'd1, 16'h0, 0, d, z, c);
        check("dep_second", d, 16'h000C);

        // Response backpressure for 5 cycles.
        do_op(T_XOR, 3'd6, 3'd3, 3'd2, 16'h0, 5, d, z, c);
        check("xor_stall", d, 16'h00FE);

        // Reset during EXEC of MOV r7,r3: the write must never happen.
        cmd_op = T_MOV; cmd_rd = 3'd7; cmd_rs1 = 3'd3; cmd_rs2 = 3'd0; cmd_valid = 1'b1;
        wr0 = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_rf_wr", rf_wr, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_write", wr_cnt - wr0, 0);
        check("midrst_no_rsp", rsp_valid, 0);
        do_op(T_MOV, 3'd0, 3'd7, 3'd0, 16'h0, 0, d, z, c);
        check("r7_untouched", d, 16'h0000);

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 2), d, z, c);
        end

        for (int i = 0; i < 8; i++) check($sformatf("final_r%0d", i), tb_rf[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rf_exec_ctrl.md
Name: rf_exec_ctrl

Overview:
- Single-issue micro-op sequencer for the 8 x 16-bit two-read/one-write register file (reg_file).
- Accepts one operation per valid/ready handshake and reads two source registers through the combinational read ports.
- Computes the result in an internal 16-bit ALU, writes it back through the write port, then returns result and flags on a valid/ready response channel.
- Sits between the instruction front end and reg_file; it is the only block driving reg_file address, write-enable and data inputs.

Parameters:
- DW, 16, data width; must match the register-file word width.
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 MOV(a), 7 LDI(imm).
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source A register.
- cmd_rs2  in  AW  source B register.
- cmd_imm  in  DW  immediate; used by LDI only.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DW  value written to rd.
- rsp_zero  out  1  rsp_data == 0.
- rsp_carry  out  1  ADD carry-out / SUB borrow; 0 for other ops.
- rf_wr  out  1  register-file write enable.
- rf_wr_addr  out  AW  register-file write address.
- rf_rd_addr_a  out  AW  register-file read port A address.
- rf_rd_addr_b  out  AW  register-file read port B address.
- rf_d_in  out  DW  register-file write data.
- rf_d_out_a  in  DW  register-file read data A (combinational from address).
- rf_d_out_b  in  DW  register-file read data B.

Behaviour:
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid&cmd_ready: latch op/rd/rs1/rs2/imm.
    - Go to EXEC if op==LDI, else READ.
  - READ:
    - Drive rf_rd_addr_a=rs1, rf_rd_addr_b=rs2.
    - At end of cycle, capture rf_d_out_a/b into operand registers; go to EXEC.
  - EXEC:
    - Compute result and carry into registers; go to WRITE.
  - WRITE:
    - rf_wr=1 for exactly one cycle, with rf_wr_addr=rd and rf_d_in=result.
    - Go to RESP.
  - RESP:
    - rsp_valid=1, holding rsp_data/rsp_zero/rsp_carry stable.
    - On rsp_ready go to IDLE.
- Latency, accept edge to rsp_valid high:
  - 4 cycles for ALU ops.
  - 3 cycles for LDI.
  - With rsp_ready tied high, throughput is 1 op per 5 cycles (4 for LDI).
- Read addresses outside READ hold their last value; they are don't-care, and the bench does not check them.
- Arithmetic:
  - ADD: {carry,result} = a+b, computed DW+1 wide.
  - SUB: result = a-b mod 2^DW; carry=1 iff a<b (unsigned).
  - Logic ops, MOV, NOT and LDI: carry=0.
  - Results wrap; no saturation.
- Hazards:
  - Write completes before rsp_valid and before the next accept, so back-to-back dependent ops always read the updated value.
  - rd may equal rs1/rs2.
- cmd_ready is low in every non-IDLE state; commands offered then are not consumed.
- rsp_valid, once asserted, stays high with constant payload until rsp_ready.
- Reset (asynchronous assert, at any time including mid-operation):
  - State=IDLE, rf_wr=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_carry=0, all address outputs=0, rf_d_in=0.
  - cmd_ready=1 on the first clock after reset release.
  - A write interrupted before WRITE never occurs.
- rf_wr is a registered output; it never glitches high outside WRITE.

Decomposition:
- Shared package rf_exec_pkg:
  - opcode constants OP_ADD..OP_LDI.
  - FSM state encoding (IDLE, READ, EXEC, WRITE, RESP).
  - DW/AW defaults.
- One sub-module, rf_exec_alu: combinational (op, a, b, imm) -> (result, carry).

Test Plan:
- Post-reset: reset low for 2 cycles, then high.
  - Expect cmd_ready=1, rsp_valid=0, rf_wr=0.
  - Expect every command-driven output (address, data, response) = 0.
- LDI r3, 0x00FF:
  - Expect rf_wr pulse of one cycle with addr 3, data 0x00FF.
  - Expect rsp_valid 3 cycles after accept, rsp_data=0x00FF, zero=0, carry=0.
- Carry and borrow:
  - LDI r1, 0xFFFF; LDI r2, 0x0001; ADD r4,r1,r2 -> rsp_data=0x0000, zero=1, carry=1.
  - Then SUB r5,r2,r1 -> rsp_data=0x0002, carry=1.
- Back-to-back dependency:
  - ADD r1,r1,r1 issued twice from r1=0x0003 -> responses 0x0006 then 0x000C.
- Response backpressure: hold rsp_ready=0 for 5 cycles during XOR r6,r3,r2 (0x00FF^0x0001).
  - Expect rsp_valid held, rsp_data=0x00FE stable, cmd_ready=0 for the whole stall.
  - Expect the next command accepted only after rsp_ready.
- Reset mid-operation:
  - Assert reset during the EXEC state of MOV r7,r3 -> no rf_wr pulse and rsp_valid=0.
  - After release, issue MOV r0,r7 -> rsp_data equals r7's prior value, i.e. r7 was unmodified.
